task_deserializer: RTL and testbench

- Inverse of the FIFO-based task serializer: accepts a serial word stream (valid/last), regroups every OUTPUT_STREAMS consecutive words into one parallel lane vector, and presents it with valid/ready/last.
- Sits between the UART RX byte path and per-lane task processing. The first word of a group goes to lane 0.
- Partial final groups are zero-padded.

---
 rtl/task_deser_pkg.sv | 18 +
 rtl/task_deser_out_stage.sv | 87 ++++++++
 rtl/task_deserializer.sv | 134 +++++++++++++
 tb/tb_task_deserializer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_deser_pkg.sv
// Shared types and helpers for the task deserializer (serial words -> parallel lane groups).
// Optional build macro used by the design: TASK_DESER_KEEP_EN.
package task_deser_pkg;

  typedef enum logic [0:0] {
    s_IDLE    = 1'b0,
    s_COLLECT = 1'b1
  } state_e;

  // Lane index width; a single lane still needs one index bit.
  function automatic int idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Lane arrays are declared per module as logic [DATA_WIDTH-1:0] name [OUTPUT_STREAMS],
  // with index 0 holding the earliest word of the group.

endpackage

// File: rtl/task_deser_out_stage.sv
// Output holding register for assembled lane groups: loads on completion, holds under backpressure.
// Optional build macro: TASK_DESER_KEEP_EN adds the per-lane keep mask.
module task_deser_out_stage
  import task_deser_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int OUTPUT_STREAMS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data [OUTPUT_STREAMS],
  input  logic                  i_last,
`ifdef TASK_DESER_KEEP_EN
  input  logic [OUTPUT_STREAMS-1:0] i_keep,
  output logic [OUTPUT_STREAMS-1:0] o_keep,
`endif
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic                  o_last,
  output logic [DATA_WIDTH-1:0] o_data [OUTPUT_STREAMS]
);

  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q [OUTPUT_STREAMS];
  logic [DATA_WIDTH-1:0] data_d [OUTPUT_STREAMS];

  // A load only arrives when the register is empty or being consumed, so it wins over consume.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    if (i_load) begin
      valid_d = 1'b1;
      last_d  = i_last;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < OUTPUT_STREAMS; gi++) begin : g_data
      assign data_d[gi] = i_load ? i_data[gi] : data_q[gi];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          data_q[gi] <= '0;
        end else begin
          data_q[gi] <= data_d[gi];
        end
      end

      assign o_data[gi] = data_q[gi];
    end
  endgenerate

`ifdef TASK_DESER_KEEP_EN
  logic [OUTPUT_STREAMS-1:0] keep_q, keep_d;

  assign keep_d = i_load ? i_keep : keep_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      keep_q <= '0;
    end else begin
      keep_q <= keep_d;
    end
  end

  assign o_keep = keep_q;
`endif

  assign o_valid = valid_q;
  assign o_last  = last_q;

endmodule

// File: rtl/task_deserializer.sv
// Regroups a serial valid/last word stream into OUTPUT_STREAMS-wide lane groups, zero-padding short groups.
// Optional build macro: TASK_DESER_KEEP_EN exposes o_keep, the mask of lanes written in each group.
module task_deserializer
  import task_deser_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int OUTPUT_STREAMS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_last,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data [OUTPUT_STREAMS],
  output logic                  o_valid,
  output logic                  o_last,
`ifdef TASK_DESER_KEEP_EN
  output logic [OUTPUT_STREAMS-1:0] o_keep,
`endif
  input  logic                  i_ready
);

  localparam int             IDX_W    = idx_width(OUTPUT_STREAMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_STREAMS - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      r_idx_q, r_idx_d;
  logic [DATA_WIDTH-1:0] lanes_q  [OUTPUT_STREAMS];
  logic [DATA_WIDTH-1:0] lanes_d  [OUTPUT_STREAMS];
  logic [DATA_WIDTH-1:0] merged   [OUTPUT_STREAMS];
  logic                  accept;
  logic                  complete;

  // Input stalls whenever a group is held, even mid-group; o_ready is low during reset.
  assign o_ready  = i_rst_n && (!o_valid || i_ready);
  assign accept   = i_valid && o_ready;
  assign complete = accept && ((r_idx_q == LAST_IDX) || i_last);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      s_IDLE: begin
        if (accept && !complete) begin
          state_d = s_COLLECT;
        end
      end
      s_COLLECT: begin
        if (complete) begin
          state_d = s_IDLE;
        end
      end
      default: state_d = s_IDLE;
    endcase
  end

  always_comb begin
    r_idx_d = r_idx_q;
    if (complete) begin
      r_idx_d = '0;
    end else if (accept) begin
      r_idx_d = r_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= s_IDLE;
      r_idx_q <= '0;
    end else begin
      state_q <= state_d;
      r_idx_q <= r_idx_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < OUTPUT_STREAMS; gi++) begin : g_lane
      logic hit;
      assign hit = (r_idx_q == IDX_W'(gi));

      // Lanes above the write index are already zero, so the merge yields padding for free.
      assign merged[gi] = hit ? i_data : lanes_q[gi];

      always_comb begin
        lanes_d[gi] = lanes_q[gi];
        if (complete) begin
          lanes_d[gi] = '0;
        end else if (accept && hit) begin
          lanes_d[gi] = i_data;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          lanes_q[gi] <= '0;
        end else begin
          lanes_q[gi] <= lanes_d[gi];
        end
      end
    end
  endgenerate

`ifdef TASK_DESER_KEEP_EN
  logic [OUTPUT_STREAMS-1:0] keep_mask;

  // Words fill lanes in order from 0, so the completing index bounds the written lanes.
  generate
    for (gi = 0; gi < OUTPUT_STREAMS; gi++) begin : g_keep
      assign keep_mask[gi] = (IDX_W'(gi) <= r_idx_q);
    end
  endgenerate
`endif

  task_deser_out_stage #(
    .DATA_WIDTH    (DATA_WIDTH),
    .OUTPUT_STREAMS(OUTPUT_STREAMS)
  ) u_out_stage (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_load (complete),
    .i_data (merged),
    .i_last (i_last),
`ifdef TASK_DESER_KEEP_EN
    .i_keep (keep_mask),
    .o_keep (o_keep),
`endif
    .i_ready(i_ready),
    .o_valid(o_valid),
    .o_last (o_last),
    .o_data (o_data)
  );

endmodule

// File: tb/tb_task_deserializer.sv
// Directed bench for task_deserializer (DATA_WIDTH=8, OUTPUT_STREAMS=3); keep checks need TASK_DESER_KEEP_EN.
module tb_task_deserializer;
  import task_deser_pkg::*;

  logic       i_clk;
  logic       i_rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_last;
  logic       o_ready;
  logic [7:0] o_data [3];
  logic       o_valid;
  logic       o_last;
  logic       i_ready;
`ifdef TASK_DESER_KEEP_EN
  logic [2:0] o_keep;
`endif

  task_deserializer #(
    .DATA_WIDTH    (8),
    .OUTPUT_STREAMS(3)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_data (i_data),
    .i_valid(i_valid),
    .i_last (i_last),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_last (o_last),
`ifdef TASK_DESER_KEEP_EN
    .o_keep (o_keep),
`endif
    .i_ready(i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  bit          mon_en = 1'b0;
  logic [24:0] got_q[$];
  logic [24:0] exp_q[$];

  function automatic logic [31:0] packed_out();
    return {8'h00, o_data[2], o_data[1], o_data[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one word and hold it until accepted; returns the number of stalled cycles.
  task automatic send(input logic [7:0] d, input logic l, output int waits);
    bit took;
    took    = 1'b0;
    waits   = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    for (int c = 0; c < 50; c++) begin
      @(negedge i_clk);
      if (o_ready) begin
        took = 1'b1;
        break;
      end
      waits++;
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (!took) check("send_timeout", 32'd0, 32'd1);
    $display("word %02h last=%0d accepted after %0d stall cycles", d, l, waits);
  endtask

  always @(negedge i_clk) begin
    if (mon_en && o_valid && i_ready) got_q.push_back({o_last, o_data[2], o_data[1], o_data[0]});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         w;
    logic [7:0] tv [6];
    logic [7:0] words [30];
    logic       lasts [30];
    int         idx;
    logic [23:0] acc;
    int         i;
    int         cyc;
    bit         took;

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_ready = 1'b1;

    // Reset state
    #3;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_data", packed_out(), 32'h0);
    check("rst_ready", 32'(o_ready), 32'd0);
`ifdef TASK_DESER_KEEP_EN
    check("rst_keep", 32'(o_keep), 32'd0);
`endif
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // 1: two full groups back to back, o_valid one cycle after each third word
    tv[0] = 8'h11; tv[1] = 8'h22; tv[2] = 8'h33;
    tv[3] = 8'h44; tv[4] = 8'h55; tv[5] = 8'h66;
    for (int k = 0; k < 6; k++) begin
      send(tv[k], k == 5, w);
      check("t1_stall", 32'(w), 32'd0);
      check("t1_valid", 32'(o_valid), 32'((k == 2) || (k == 5)));
    end
    check("t1_g2_data", packed_out(), 32'h00665544);
    check("t1_g2_last", 32'(o_last), 32'd1);
`ifdef TASK_DESER_KEEP_EN
    check("t1_g2_keep", 32'(o_keep), 32'b111);
`endif

    // 2: short frame padded with zeros
    send(8'hA1, 1'b0, w);
    check("t2_mid_valid", 32'(o_valid), 32'd0);
    send(8'hA2, 1'b1, w);
    check("t2_valid", 32'(o_valid), 32'd1);
    check("t2_data", packed_out(), 32'h0000A2A1);
    check("t2_last", 32'(o_last), 32'd1);
`ifdef TASK_DESER_KEEP_EN
    check("t2_keep", 32'(o_keep), 32'b011);
`endif

    // 4: single-word frame lands in lane 0, FSM never leaves idle
    send(8'h7E, 1'b1, w);
    check("t4_data", packed_out(), 32'h0000007E);
    check("t4_last", 32'(o_last), 32'd1);
    check("t4_state", 32'(dut.state_q), 32'(s_IDLE));
`ifdef TASK_DESER_KEEP_EN
    check("t4_keep", 32'(o_keep), 32'b001);
`endif
    @(posedge i_clk);
    #1;

    // 3: backpressure holds the group and the next word
    i_ready = 1'b0;
    send(8'h11, 1'b0, w);
    send(8'h22, 1'b0, w);
    send(8'h33, 1'b0, w);
    check("t3_valid", 32'(o_valid), 32'd1);
    i_valid = 1'b1;
    i_data  = 8'h44;
    i_last  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("t3_ready_low", 32'(o_ready), 32'd0);
      check("t3_hold_data", packed_out(), 32'h00332211);
      check("t3_hold_last", 32'(o_last), 32'd0);
      @(posedge i_clk);
      #1;
    end
    i_ready = 1'b1;
    send(8'h44, 1'b0, w);
    check("t3_resume_stall", 32'(w), 32'd0);
    check("t3_consumed", 32'(o_valid), 32'd0);
    send(8'h55, 1'b0, w);
    send(8'h66, 1'b1, w);
    check("t3_data", packed_out(), 32'h00665544);
    check("t3_last", 32'(o_last), 32'd1);

    // 5: async reset clears a held group immediately
    i_ready = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t5_held_valid", 32'(o_valid), 32'd0);
    check("t5_held_last", 32'(o_last), 32'd0);
    check("t5_held_data", packed_out(), 32'h0);
    check("t5_ready", 32'(o_ready), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    send(8'h11, 1'b0, w);
    send(8'h22, 1'b0, w);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t5_mid_valid", 32'(o_valid), 32'd0);
    check("t5_mid_ready", 32'(o_ready), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    send(8'h33, 1'b0, w);
    send(8'h44, 1'b0, w);
    send(8'h55, 1'b0, w);
    check("t5_valid", 32'(o_valid), 32'd1);
    check("t5_data", packed_out(), 32'h00554433);
    check("t5_last", 32'(o_last), 32'd0);
    @(posedge i_clk);
    #1;

    // 6: continuous input, toggling i_ready, scoreboard against a regrouping model
    for (int k = 0; k < 30; k++) begin
      words[k] = 8'($urandom_range(0, 255));
      lasts[k] = (k == 29) ? 1'b1 : ($urandom_range(0, 3) == 0);
    end
    idx = 0;
    acc = '0;
    for (int k = 0; k < 30; k++) begin
      acc = acc | (24'(words[k]) << (8 * idx));
      if (idx == 2 || lasts[k]) begin
        exp_q.push_back({lasts[k], acc});
        acc = '0;
        idx = 0;
      end else begin
        idx++;
      end
    end
    mon_en  = 1'b1;
    i       = 0;
    cyc     = 0;
    i_valid = 1'b1;
    i_data  = words[0];
    i_last  = lasts[0];
    while (i < 30 && cyc < 400) begin
      @(negedge i_clk);
      took = o_ready;
      @(posedge i_clk);
      #1;
      cyc++;
      i_ready = ~i_ready;
      if (took) begin
        $display("word %02h last=%0d accepted in stream", words[i], lasts[i]);
        i++;
        if (i < 30) begin
          i_data = words[i];
          i_last = lasts[i];
        end
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    check("t6_all_sent", 32'(i), 32'd30);
    repeat (4) @(posedge i_clk);
    #1;
    mon_en = 1'b0;
    check("t6_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      $display("group %0d: got %07h expected %07h", k, got_q[k], exp_q[k]);
      check("t6_group", 32'(got_q[k]), 32'(exp_q[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
